// File: rtl/fetch_unit.sv
// Program-counter and opcode-fetch stage: holds PCH:PCL, fetches opcode bytes
// from program ROM through a ready handshake, and drives PC bytes onto the bus.
module fetch_unit #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter int          ROM_TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  output logic        fetch_busy,
  output logic        ir_valid,
  output logic [7:0]  instruction,
  output logic        fetch_err,
  output logic [15:0] pc,
  input  logic        pc_inc,
  input  logic        pcl_car,
  input  logic        pch_car,
  input  logic        pcl_bus,
  input  logic        pch_bus,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic [15:0] rom_addr,
  output logic        rom_cs,
  output logic        rom_rd,
  input  logic [7:0]  rom_data,
  input  logic        rom_ready
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  localparam logic [7:0] WAIT_LAST = 8'(ROM_TIMEOUT - 1);

  logic [0:0] state;
  logic [7:0] wait_cnt;
  logic       auto_inc;

  assign fetch_busy = (state == REQ);
  assign rom_cs     = (state == REQ);
  assign rom_rd     = (state == REQ);
  assign auto_inc   = (state == REQ) && rom_ready;

  // The low byte wins when both bus enables are asserted.
  always_comb begin
    data_out = 8'h00;
    if (pcl_bus)
      data_out = pc[7:0];
    else if (pch_bus)
      data_out = pc[15:8];
  end

  assign data_oe = pcl_bus | pch_bus;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_VECTOR;
      instruction <= 8'h00;
      ir_valid    <= 1'b0;
      fetch_err   <= 1'b0;
      rom_addr    <= 16'h0000;
      wait_cnt    <= 8'h00;
    end else begin
      ir_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_req) begin
            rom_addr  <= pc;
            wait_cnt  <= 8'h00;
            fetch_err <= 1'b0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (rom_ready) begin
            instruction <= rom_data;
            ir_valid    <= 1'b1;
            state       <= IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            fetch_err <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase

      // A byte load blocks every increment source; both sources merge into one +1.
      if (pcl_car || pch_car) begin
        if (pcl_car)
          pc[7:0] <= data_in;
        if (pch_car)
          pc[15:8] <= data_in;
      end else if (auto_inc || pc_inc) begin
        pc <= pc + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_fetch_unit;

  localparam logic [15:0] RV = 16'h0100;
  localparam int          TO = 15;

  logic        clk = 1'b0;
  logic        rst, fetch_req, pc_inc, pcl_car, pch_car, pcl_bus, pch_bus, rom_ready;
  logic [7:0]  data_in, rom_data;
  logic        fetch_busy, ir_valid, fetch_err, data_oe, rom_cs, rom_rd;
  logic [7:0]  instruction, data_out;
  logic [15:0] pc, rom_addr;

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the architectural state as seen after the most recent edge.
  bit          m_known = 0;
  bit          m_busy, m_valid, m_err;
  int          m_wait, m_pc;
  logic [7:0]  m_instr;
  logic [15:0] m_addr;

  fetch_unit #(.RESET_VECTOR(RV), .ROM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_busy(fetch_busy),
    .ir_valid(ir_valid), .instruction(instruction), .fetch_err(fetch_err), .pc(pc),
    .pc_inc(pc_inc), .pcl_car(pcl_car), .pch_car(pch_car), .pcl_bus(pcl_bus),
    .pch_bus(pch_bus), .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_rd(rom_rd), .rom_data(rom_data),
    .rom_ready(rom_ready)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic req, input logic rdy,
                                input logic [7:0] rdata, input logic inc,
                                input logic lcar, input logic hcar, input logic [7:0] din);
    rst = r; fetch_req = req; rom_ready = rdy; rom_data = rdata;
    pc_inc = inc; pcl_car = lcar; pch_car = hcar; data_in = din;
  endtask

  // Compares every DUT output with the model's current state and current inputs.
  task automatic check_output();
    logic [7:0] exp_bus;
    if (!m_known) return;
    exp_bus = pcl_bus ? m_pc[7:0] : (pch_bus ? m_pc[15:8] : 8'h00);
    cmp("pc", pc, m_pc[15:0]);
    cmp("instruction", {8'h00, instruction}, {8'h00, m_instr});
    cmp("ir_valid", {15'h0, ir_valid}, {15'h0, m_valid});
    cmp("fetch_err", {15'h0, fetch_err}, {15'h0, m_err});
    cmp("fetch_busy", {15'h0, fetch_busy}, {15'h0, m_busy});
    cmp("rom_cs", {15'h0, rom_cs}, {15'h0, m_busy});
    cmp("rom_rd", {15'h0, rom_rd}, {15'h0, m_busy});
    cmp("rom_addr", rom_addr, m_addr);
    cmp("data_out", {8'h00, data_out}, {8'h00, exp_bus});
    cmp("data_oe", {15'h0, data_oe}, {15'h0, pcl_bus | pch_bus});
  endtask

  // Advance the model by one clock edge using the currently applied inputs.
  task automatic model_advance();
    bit done;
    done = 0;
    if (rst) begin
      m_known = 1; m_busy = 0; m_valid = 0; m_err = 0; m_wait = 0;
      m_pc = RV; m_instr = 8'h00; m_addr = 16'h0000;
      return;
    end
    if (m_busy) begin
      if (rom_ready) begin
        m_instr = rom_data; done = 1; m_busy = 0;
      end else begin
        m_wait++;
        if (m_wait == TO) begin
          m_err = 1; m_busy = 0;
        end
      end
    end else if (fetch_req) begin
      m_addr = m_pc[15:0]; m_busy = 1; m_wait = 0; m_err = 0;
    end
    m_valid = done;
    if (pcl_car || pch_car) begin
      if (pcl_car) m_pc = (m_pc & 16'hFF00) | data_in;
      if (pch_car) m_pc = (m_pc & 16'h00FF) | (int'(data_in) << 8);
    end else if (done || pc_inc) begin
      m_pc = (m_pc + 1) % 65536;
    end
  endtask

  task automatic tick();
    #1;
    check_output();
    model_advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    pcl_bus = 0; pch_bus = 0;
    apply_stimulus(1, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    @(negedge clk);
    tick();

    // Reset values and a zero-wait fetch.
    apply_stimulus(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    #1;
    cmp("lit_reset_pc", pc, 16'h0100);
    cmp("lit_reset_busy", {15'h0, fetch_busy | rom_cs | rom_rd | ir_valid | fetch_err}, 16'h0);
    cmp("lit_reset_addr", rom_addr, 16'h0000);
    cmp("lit_reset_bus", {7'h0, data_oe, data_out}, 16'h0000);
    apply_stimulus(0, 1, 1, 8'hA5, 0, 0, 0, 8'h00);
    tick();
    apply_stimulus(0, 0, 1, 8'hA5, 0, 0, 0, 8'h00);
    tick();
    cmp("lit_f1_addr", rom_addr, 16'h0100);
    cmp("lit_f1_instr", {8'h00, instruction}, 16'h00A5);
    cmp("lit_f1_valid", {15'h0, ir_valid}, 16'h1);
    cmp("lit_f1_pc", pc, 16'h0101);
    apply_stimulus(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    tick();
    cmp("lit_f1_valid_drop", {15'h0, ir_valid}, 16'h0);

    // Delayed ready with a PC load in the middle of the request.
    apply_stimulus(0, 1, 0, 8'h00, 0, 0, 0, 8'h00);
    tick();
    apply_stimulus(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    tick();
    apply_stimulus(0, 0, 0, 8'h00, 0, 1, 1, 8'h12);
    tick();
    apply_stimulus(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    tick();
    cmp("lit_f2_addr", rom_addr, 16'h0101);
    cmp("lit_f2_pc_load", pc, 16'h1212);
    cmp("lit_f2_busy", {15'h0, fetch_busy}, 16'h1);
    apply_stimulus(0, 0, 1, 8'h3C, 0, 0, 0, 8'h00);
    tick();
    cmp("lit_f2_pc", pc, 16'h1213);
    cmp("lit_f2_instr", {8'h00, instruction}, 16'h003C);

    // Wrap-around and load-over-increment priority.
    apply_stimulus(0, 0, 0, 8'h00, 0, 1, 1, 8'hFF);
    tick();
    apply_stimulus(0, 0, 0, 8'h00, 1, 0, 0, 8'h00);
    tick();
    cmp("lit_wrap", pc, 16'h0000);
    apply_stimulus(0, 0, 0, 8'h00, 1, 1, 0, 8'h40);
    tick();
    cmp("lit_load_beats_inc", pc, 16'h0040);

    // ROM timeout.
    apply_stimulus(0, 1, 0, 8'h00, 0, 0, 0, 8'h00);
    tick();
    apply_stimulus(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    repeat (TO - 1) tick();
    cmp("lit_to_early", {14'h0, fetch_err, fetch_busy}, 16'h0001);
    tick();
    cmp("lit_to_err", {14'h0, fetch_err, fetch_busy}, 16'h0002);
    cmp("lit_to_pc", pc, 16'h0040);
    cmp("lit_to_instr", {8'h00, instruction}, 16'h003C);
    apply_stimulus(0, 1, 0, 8'h00, 0, 0, 0, 8'h00);
    tick();
    cmp("lit_to_clear", {14'h0, fetch_err, fetch_busy}, 16'h0001);
    apply_stimulus(0, 0, 1, 8'h5A, 0, 0, 0, 8'h00);
    tick();

    // Bus transfers from PC = BE01.
    apply_stimulus(0, 0, 0, 8'h00, 0, 0, 1, 8'hBE);
    tick();
    apply_stimulus(0, 0, 0, 8'h00, 0, 1, 0, 8'h01);
    tick();
    apply_stimulus(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    pch_bus = 1;
    #1;
    cmp("lit_bus_pch", {7'h0, data_oe, data_out}, 16'h01BE);
    pcl_bus = 1;
    #1;
    cmp("lit_bus_both", {7'h0, data_oe, data_out}, 16'h0101);
    tick();
    pcl_bus = 0; pch_bus = 0;

    // Reset in the middle of a request.
    apply_stimulus(0, 1, 0, 8'h00, 0, 0, 0, 8'h00);
    tick();
    apply_stimulus(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    tick();
    apply_stimulus(1, 0, 1, 8'h77, 0, 0, 0, 8'h00);
    tick();
    cmp("lit_rst_mid", {13'h0, fetch_busy, rom_cs, ir_valid}, 16'h0000);
    cmp("lit_rst_pc", pc, 16'h0100);
    apply_stimulus(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    tick();
    cmp("lit_rst_no_valid", {15'h0, ir_valid}, 16'h0);

    // Randomized traffic with occasional long ROM stalls and resets.
    begin
      int stall = 0;
      for (int i = 0; i < 3000; i++) begin
        if (stall == 0 && $urandom_range(0, 60) == 0) stall = $urandom_range(5, 40);
        apply_stimulus($urandom_range(0, 250) == 0,
                       $urandom_range(0, 2) == 0,
                       (stall == 0) && ($urandom_range(0, 2) == 0),
                       8'($urandom),
                       $urandom_range(0, 5) == 0,
                       $urandom_range(0, 9) == 0,
                       $urandom_range(0, 9) == 0,
                       8'($urandom));
        pcl_bus = $urandom_range(0, 3) == 0;
        pch_bus = $urandom_range(0, 3) == 0;
        if (stall > 0) stall--;
        tick();
      end
    end
    #1;
    check_output();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
